// File: rtl/burst_ram_responder_pkg.sv
// Shared parameter defaults and FSM state encoding for the burst RAM responder.
package burst_ram_responder_pkg;

    localparam int DEF_MEM_DATA_BITS  = 16;
    localparam int DEF_ADDR_BITS      = 24;
    localparam int DEF_BURST_BITS     = 10;
    localparam int DEF_RAM_DEPTH_BITS = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_READ   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/burst_ram_sdp.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
module burst_ram_sdp #(
    parameter int DATA_BITS  = 16,
    parameter int DEPTH_BITS = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0]  wdata,
    input  logic                  re,
    input  logic [DEPTH_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0]  rdata
);

    logic [DATA_BITS-1:0] mem [0:(1<<DEPTH_BITS)-1];
    logic [DATA_BITS-1:0] rdata_reg;

    // No reset on purpose: contents survive reset and this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/burst_ram_responder.sv
// Burst responder: accepts write/read bursts from a requester and serves them
// from an internal block RAM; writes win when both requests are pending.
module burst_ram_responder
    import burst_ram_responder_pkg::*;
#(
    parameter int MEM_DATA_BITS  = DEF_MEM_DATA_BITS,
    parameter int ADDR_BITS      = DEF_ADDR_BITS,
    parameter int BURST_BITS     = DEF_BURST_BITS,
    parameter int RAM_DEPTH_BITS = DEF_RAM_DEPTH_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_burst_req,
    input  logic [BURST_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    input  logic                     rd_burst_req,
    input  logic [BURST_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish
);

    state_t                    state_reg, state_next;
    logic [ADDR_BITS-1:0]      addr_reg, addr_next;
    logic [BURST_BITS-1:0]     len_reg, len_next;
    logic [BURST_BITS-1:0]     cnt_reg, cnt_next;
    logic                      is_wr_reg, is_wr_next;
    logic                      drain_reg, drain_next;
    logic                      wr_en_reg;
    logic [RAM_DEPTH_BITS-1:0] wr_idx_reg;
    logic                      rd_valid_reg;

    logic                      data_req;
    logic                      rd_issue;
    logic                      fin_pulse;
    logic [ADDR_BITS-1:0]      cur_addr;
    logic                      addr_hi_unused;
    logic [MEM_DATA_BITS-1:0]  ram_q;

    assign cur_addr       = addr_reg + ADDR_BITS'(cnt_reg);
    // Upper address bits only take part in the modulo arithmetic; the RAM sees the low bits.
    assign addr_hi_unused = ^cur_addr[ADDR_BITS-1:RAM_DEPTH_BITS];

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        is_wr_next = is_wr_reg;
        drain_next = drain_reg;
        data_req   = 1'b0;
        rd_issue   = 1'b0;
        fin_pulse  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next   = '0;
                drain_next = 1'b0;
                if (wr_burst_req) begin
                    addr_next  = wr_burst_addr;
                    len_next   = wr_burst_len;
                    is_wr_next = 1'b1;
                    state_next = (wr_burst_len == '0) ? ST_FINISH : ST_WRITE;
                end else if (rd_burst_req) begin
                    addr_next  = rd_burst_addr;
                    len_next   = rd_burst_len;
                    is_wr_next = 1'b0;
                    state_next = (rd_burst_len == '0) ? ST_FINISH : ST_READ;
                end
            end
            ST_WRITE, ST_READ: begin
                data_req = (state_reg == ST_WRITE);
                rd_issue = (state_reg == ST_READ);
                cnt_next = cnt_reg + BURST_BITS'(1);
                if (cnt_reg == len_reg - BURST_BITS'(1)) begin
                    state_next = ST_FINISH;
                end
            end
            default: begin
                // One drain cycle lets the last write land / last read word leave the RAM.
                if (drain_reg) begin
                    fin_pulse  = 1'b1;
                    drain_next = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    drain_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            len_reg      <= '0;
            cnt_reg      <= '0;
            is_wr_reg    <= 1'b0;
            drain_reg    <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_idx_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            len_reg      <= len_next;
            cnt_reg      <= cnt_next;
            is_wr_reg    <= is_wr_next;
            drain_reg    <= drain_next;
            wr_en_reg    <= data_req;
            wr_idx_reg   <= cur_addr[RAM_DEPTH_BITS-1:0];
            rd_valid_reg <= rd_issue;
        end
    end

    burst_ram_sdp #(
        .DATA_BITS  (MEM_DATA_BITS),
        .DEPTH_BITS (RAM_DEPTH_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en_reg),
        .waddr (wr_idx_reg),
        .wdata (wr_burst_data),
        .re    (rd_issue),
        .raddr (cur_addr[RAM_DEPTH_BITS-1:0]),
        .rdata (ram_q)
    );

    assign wr_burst_data_req   = data_req;
    assign wr_burst_finish     = fin_pulse && is_wr_reg;
    assign rd_burst_finish     = fin_pulse && !is_wr_reg;
    assign rd_burst_data_valid = rd_valid_reg;
    assign rd_burst_data       = rd_valid_reg ? ram_q : '0;

endmodule

// File: tb/tb_burst_ram_responder.sv
// Scoreboard bench for burst_ram_responder: read words are predicted when a
// read is requested and compared as the responder streams them out.
module tb_burst_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_burst_req;
    logic [9:0]  wr_burst_len;
    logic [23:0] wr_burst_addr;
    logic        wr_burst_data_req;
    logic [15:0] wr_burst_data;
    logic        wr_burst_finish;
    logic        rd_burst_req;
    logic [9:0]  rd_burst_len;
    logic [23:0] rd_burst_addr;
    logic        rd_burst_data_valid;
    logic [15:0] rd_burst_data;
    logic        rd_burst_finish;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] wr_words[$];
    logic        prev_wr_fin = 1'b0;
    logic        prev_rd_fin = 1'b0;

    always #5 clk = ~clk;

    burst_ram_responder dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish)
    );

    // Scoreboard pop plus exclusivity / pulse-width checks on every cycle.
    always @(negedge clk) begin
        logic [15:0] exp_w;
        checks++;
        if (rd_burst_data_valid) begin
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_unexpected got %h required none", rd_burst_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (rd_burst_data !== exp_w) begin
                    errors++; $display("FAIL sb_data got %h required %h", rd_burst_data, exp_w);
                end
            end
        end else if (rd_burst_data !== 16'h0) begin
            errors++; $display("FAIL rd_data_idle got %h required 0000", rd_burst_data);
        end
        if (wr_burst_data_req && rd_burst_data_valid) begin
            errors++; $display("FAIL excl_data got req=1 valid=1 required one-hot");
        end
        if (wr_burst_finish && rd_burst_finish) begin
            errors++; $display("FAIL excl_finish got both=1 required one-hot");
        end
        if ((wr_burst_finish && prev_wr_fin) || (rd_burst_finish && prev_rd_fin)) begin
            errors++; $display("FAIL finish_width got 2+ cycles required 1");
        end
        prev_wr_fin = wr_burst_finish;
        prev_rd_fin = rd_burst_finish;
    end

    // Drives one write burst, supplying word k the cycle after the k-th data_req.
    task automatic drive_write(input logic [23:0] addr, input int len, input int abort_at,
                               output int n_req, output int first_req, output int last_req,
                               output int fin_i, output int n_fin);
        int   widx = 0;
        logic prev = 1'b0;
        n_req = 0; first_req = -1; last_req = -1; fin_i = -1; n_fin = 0;
        wr_burst_addr = addr; wr_burst_len = 10'(len); wr_burst_req = 1'b1;
        for (int i = 1; i <= len + 10; i++) begin
            @(negedge clk);
            if (prev && widx < wr_words.size()) begin
                wr_burst_data = wr_words[widx];
                widx++;
            end
            prev = wr_burst_data_req;
            if (wr_burst_data_req) begin
                n_req++; if (first_req < 0) first_req = i; last_req = i;
            end
            if (wr_burst_finish) begin
                n_fin++; fin_i = i; break;
            end
            if (i == abort_at) begin
                rst_n = 1'b0; break;
            end
        end
        wr_burst_req = 1'b0;
        $display("write addr=%h len=%0d reqs=%0d finish_cycle=%0d", addr, len, n_req, fin_i);
    endtask

    task automatic drive_read(input logic [23:0] addr, input int len,
                              output int n_val, output int first_val, output int last_val,
                              output int fin_i, output int n_fin);
        n_val = 0; first_val = -1; last_val = -1; fin_i = -1; n_fin = 0;
        rd_burst_addr = addr; rd_burst_len = 10'(len); rd_burst_req = 1'b1;
        for (int i = 1; i <= len + 10; i++) begin
            @(negedge clk);
            if (rd_burst_data_valid) begin
                n_val++; if (first_val < 0) first_val = i; last_val = i;
            end
            if (rd_burst_finish) begin
                n_fin++; fin_i = i; break;
            end
        end
        rd_burst_req = 1'b0;
        $display("read  addr=%h len=%0d valids=%0d finish_cycle=%0d", addr, len, n_val, fin_i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_burst_req = 1'b0; rd_burst_req = 1'b0;
        wr_burst_len = '0; wr_burst_addr = '0; wr_burst_data = '0;
        rd_burst_len = '0; rd_burst_addr = '0;
        repeat (3) @(negedge clk);
        checks++; if (wr_burst_data_req !== 1'b0) begin errors++; $display("FAIL rst_data_req got %b required 0", wr_burst_data_req); end
        checks++; if (wr_burst_finish !== 1'b0) begin errors++; $display("FAIL rst_wr_finish got %b required 0", wr_burst_finish); end
        checks++; if (rd_burst_data_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", rd_burst_data_valid); end
        checks++; if (rd_burst_finish !== 1'b0) begin errors++; $display("FAIL rst_rd_finish got %b required 0", rd_burst_finish); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_write_read_128();
        int nr, fr, lr, fi, nf;
        wr_words.delete();
        for (int k = 0; k < 128; k++) wr_words.push_back(16'(k));
        drive_write(24'h000000, 128, -1, nr, fr, lr, fi, nf);
        checks++; if (nr != 128) begin errors++; $display("FAIL w128_nreq got %0d required 128", nr); end
        checks++; if (fr != 1 || lr != 128) begin errors++; $display("FAIL w128_window got %0d..%0d required 1..128", fr, lr); end
        checks++; if (fi != 130 || nf != 1) begin errors++; $display("FAIL w128_finish got cyc %0d n %0d required 130 1", fi, nf); end
        @(negedge clk);
        for (int k = 0; k < 128; k++) exp_q.push_back(16'(k));
        drive_read(24'h000000, 128, nr, fr, lr, fi, nf);
        checks++; if (nr != 128) begin errors++; $display("FAIL r128_nvalid got %0d required 128", nr); end
        checks++; if (fr != 2 || lr != 129) begin errors++; $display("FAIL r128_window got %0d..%0d required 2..129", fr, lr); end
        checks++; if (fi != 130 || nf != 1) begin errors++; $display("FAIL r128_finish got cyc %0d n %0d required 130 1", fi, nf); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL r128_drain got %0d left required 0", exp_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int nr, fr, lr, fi, nf;
        wr_words.delete();
        wr_words.push_back(16'hAAAA); wr_words.push_back(16'hBBBB);
        wr_words.push_back(16'hCCCC); wr_words.push_back(16'hDDDD);
        drive_write(24'h000FFE, 4, -1, nr, fr, lr, fi, nf);
        checks++; if (nr != 4 || fi != 6) begin errors++; $display("FAIL wrap_write got n %0d fin %0d required 4 6", nr, fi); end
        @(negedge clk);
        exp_q.push_back(16'hAAAA); exp_q.push_back(16'hBBBB);
        exp_q.push_back(16'hCCCC); exp_q.push_back(16'hDDDD);
        drive_read(24'h000FFE, 4, nr, fr, lr, fi, nf);
        checks++; if (nr != 4 || fi != 6) begin errors++; $display("FAIL wrap_read got n %0d fin %0d required 4 6", nr, fi); end
        @(negedge clk);
        // Index 0 and 1 must hold the wrapped words C and D.
        exp_q.push_back(16'hCCCC); exp_q.push_back(16'hDDDD);
        drive_read(24'h000000, 2, nr, fr, lr, fi, nf);
        checks++; if (nr != 2 || exp_q.size() != 0) begin errors++; $display("FAIL wrap_low got n %0d left %0d required 2 0", nr, exp_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int   widx = 0, nreq = 0, wfin = -1, fval = -1, rfin = -1, overlap = 0;
        logic prev = 1'b0;
        wr_words.delete();
        wr_words.push_back(16'h1111); wr_words.push_back(16'h2222); wr_words.push_back(16'h3333);
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
        wr_burst_addr = 24'h000200; wr_burst_len = 10'd3; wr_burst_req = 1'b1;
        rd_burst_addr = 24'h000200; rd_burst_len = 10'd3; rd_burst_req = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (prev && widx < 3) begin wr_burst_data = wr_words[widx]; widx++; end
            prev = wr_burst_data_req;
            if (wr_burst_data_req) nreq++;
            if (rd_burst_data_valid && fval < 0) fval = i;
            if (rd_burst_data_valid && wfin < 0) overlap++;
            if (wr_burst_finish) begin wfin = i; wr_burst_req = 1'b0; end
            if (rd_burst_finish) begin rfin = i; break; end
        end
        rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        $display("both  write_fin=%0d read_first_valid=%0d read_fin=%0d", wfin, fval, rfin);
        checks++; if (nreq != 3 || wfin != 5) begin errors++; $display("FAIL b2b_write got n %0d fin %0d required 3 5", nreq, wfin); end
        checks++; if (overlap != 0) begin errors++; $display("FAIL b2b_order got %0d early reads required 0", overlap); end
        checks++; if (fval != 8 || rfin != 11) begin errors++; $display("FAIL b2b_read got first %0d fin %0d required 8 11", fval, rfin); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d left required 0", exp_q.size()); end
        @(negedge clk);
    endtask

    task automatic test_len0();
        int nr, fr, lr, fi, nf;
        drive_read(24'h000010, 0, nr, fr, lr, fi, nf);
        checks++; if (nr != 0 || fi != 2 || nf != 1) begin errors++; $display("FAIL len0_read got n %0d fin %0d nf %0d required 0 2 1", nr, fi, nf); end
        @(negedge clk);
        wr_words.delete();
        drive_write(24'h000010, 0, -1, nr, fr, lr, fi, nf);
        checks++; if (nr != 0 || fi != 2 || nf != 1) begin errors++; $display("FAIL len0_write got n %0d fin %0d nf %0d required 0 2 1", nr, fi, nf); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int nr, fr, lr, fi, nf, late_fin = 0;
        wr_words.delete();
        for (int k = 0; k < 128; k++) wr_words.push_back(16'h5000 + 16'(k));
        drive_write(24'h000400, 128, 60, nr, fr, lr, fi, nf);
        #1;
        checks++; if (nr != 60 || nf != 0) begin errors++; $display("FAIL abort_count got n %0d nf %0d required 60 0", nr, nf); end
        checks++; if (wr_burst_data_req !== 1'b0 || wr_burst_finish !== 1'b0) begin errors++; $display("FAIL abort_outputs got req %b fin %b required 0 0", wr_burst_data_req, wr_burst_finish); end
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (wr_burst_finish || wr_burst_data_req) late_fin++; end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (wr_burst_finish || wr_burst_data_req) late_fin++; end
        checks++; if (late_fin != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles required 0", late_fin); end
        wr_words.delete();
        for (int k = 0; k < 8; k++) wr_words.push_back(16'h7700 + 16'(k));
        drive_write(24'h000300, 8, -1, nr, fr, lr, fi, nf);
        checks++; if (nr != 8 || fi != 10 || nf != 1) begin errors++; $display("FAIL post_rst_write got n %0d fin %0d nf %0d required 8 10 1", nr, fi, nf); end
        @(negedge clk);
        for (int k = 0; k < 8; k++) exp_q.push_back(16'h7700 + 16'(k));
        drive_read(24'h000300, 8, nr, fr, lr, fi, nf);
        checks++; if (nr != 8 || fi != 10 || exp_q.size() != 0) begin errors++; $display("FAIL post_rst_read got n %0d fin %0d left %0d required 8 10 0", nr, fi, exp_q.size()); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write_read_128();
        test_wrap();
        test_back_to_back();
        test_len0();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
